// File: rtl/down_counter.sv
// Loadable WIDTH-bit down-counter/timer with a registered terminal-count pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to restart from the reload value instead of stopping in DONE.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      out_d    = data;
      reload_d = data;
      state_d  = (data != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            // out is never 0 in RUN, so the decrement cannot wrap
            if (out_q == WIDTH'(1)) begin
              tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              out_d   = reload_q;
              state_d = RUN;
`else
              out_d   = '0;
              state_d = DONE;
`endif
            end else begin
              out_d = out_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          out_d = '0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: random and directed vectors against a timer model.
// Handshake: every rising edge produces one output vector; the monitor pops one expectation per edge.
module tb_down_counter;
  localparam int WIDTH = 8;
  localparam int EW    = WIDTH + 3;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             en;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             busy;
  logic             done;

  logic [EW-1:0] exp_q[$];
  int vectors;
  int miscompares;

  // Timer model: remaining count, whether it is counting, whether it has finished.
  int m_out;
  int m_rel;
  bit m_tc;
  bit m_run;
  bit m_fin;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .data (data),
    .en   (en),
    .out  (out),
    .tc   (tc),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit ld, input int d, input bit e);
    if (!r) begin
      m_out = 0; m_rel = 0; m_tc = 0; m_run = 0; m_fin = 0;
    end else if (ld) begin
      m_out = d; m_rel = d; m_tc = 0; m_run = (d != 0); m_fin = 0;
    end else if (m_run && e) begin
      m_out = m_out - 1;
      m_tc  = 0;
      if (m_out == 0) begin
        m_tc = 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        m_out = m_rel;
`else
        m_run = 0;
        m_fin = 1;
`endif
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic apply(input bit r, input bit ld, input int d, input bit e);
    logic [EW-1:0] v;
    @(negedge clk);
    reset = r;
    load  = ld;
    data  = WIDTH'(d);
    en    = e;
    model_step(r, ld, d, e);
    v = {WIDTH'(m_out), m_tc, m_run, m_fin};
    exp_q.push_back(v);
  endtask

  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({out, tc, busy, done} !== e) begin
          miscompares++;
          $display("FAIL vec%0d: out=%0d tc=%0b busy=%0b done=%0b, required out=%0d tc=%0b busy=%0b done=%0b",
                   vectors, out, tc, busy, done, e[EW-1:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : stimulus
    vectors = 0;
    miscompares = 0;
    reset = 1'b0; load = 1'b0; data = '0; en = 1'b0;

    // Reset overrides a concurrent load.
    apply(0, 1, 8'hAA, 0);
    apply(0, 1, 8'hAA, 0);
    // Load 5 and count out, then sit in the terminal state.
    apply(1, 1, 5, 0);
    for (int i = 0; i < 8; i++) apply(1, 0, 0, 1);
    // Pause mid-count.
    apply(1, 1, 4, 0);
    apply(1, 0, 0, 1); apply(1, 0, 0, 1);
    apply(1, 0, 0, 0); apply(1, 0, 0, 0); apply(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply(1, 0, 0, 1);
    // Load colliding with the terminal edge.
    apply(1, 1, 3, 0);
    apply(1, 0, 0, 1); apply(1, 0, 0, 1);
    apply(1, 1, 7, 1);
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 1);
    // Reset during RUN discards the count.
    apply(0, 0, 0, 1);
    apply(1, 0, 0, 1);
    // Load of zero never fires.
    apply(1, 1, 0, 1);
    for (int i = 0; i < 10; i++) apply(1, 0, 0, 1);
    // Auto-reload period check (plain terminal stop otherwise).
    apply(1, 1, 3, 1);
    for (int i = 0; i < 9; i++) apply(1, 0, 0, 1);
    apply(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) apply(1, 0, 0, 1);
    // Full-scale start value.
    apply(1, 1, 255, 1);
    for (int i = 0; i < 258; i++) apply(1, 0, 0, 1);

    // Random traffic, biased toward short loads so terminal events are frequent.
    for (int i = 0; i < 1500; i++) begin
      bit r, ld, e;
      int d;
      r  = ($urandom_range(0, 59) != 0);
      ld = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      apply(r, ld, d, e);
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable WIDTH-bit down-counter/timer; the counting-down counterpart of the team's loadable up-counter.
- Loaded with a start value, decrements on enable, and flags terminal count when it reaches zero.
- Used as a programmable delay/timeout source beside the up-counter.
- Driven by the same vector-file benches: one vector per rising clk edge, checked on the following edge.

Parameters:
- WIDTH, 8, width of data, out and the internal reload register.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- load  input  1  load request; data is captured on a rising edge where load=1.
- data  input  WIDTH  start/reload value.
- en  input  1  count enable.
- out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, 1 cycle wide.
- busy  output  1  high while in RUN.
- done  output  1  sticky completion flag, high in DONE.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is synchronous and active-low, port name reset.
  - No asynchronous paths; all outputs are registered.
- Reset (reset=0 at a rising edge):
  - out=0, tc=0, busy=0, done=0.
  - Reload register = 0, state = IDLE.
  - Reset overrides load and en in the same cycle.
- States:
  - IDLE: busy=0, done=0, out holds.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, out=0.
- Priority at each rising edge with reset=1: load > terminal event > decrement > hold.
- Load (any state):
  - out <= data and reload register <= data.
  - tc <= 0.
  - Next state is RUN if data != 0, otherwise IDLE.
  - A load of 0 never produces tc.
- RUN, en=1, out > 1: out <= out - 1, tc <= 0.
- RUN, en=1, out == 1 (terminal event): out <= 0, tc <= 1, next state DONE (see Optional Feature for the alternative).
- RUN, en=0: out holds, tc <= 0; the count pauses with no loss.
- DONE: holds until load or reset; en is ignored.
- tc is asserted only in the cycle after the terminal edge and clears on the next edge.
- Latency: after a load of N with en held high, tc is high during clock N after the load edge, and out=0 at the same time.
- Arithmetic:
  - Unsigned decrement.
  - out never goes below 0 and never wraps to all-ones.
  - A start value of 2^WIDTH-1 is legal.
- Simultaneous load and terminal event: load wins, tc=0, new value is taken.
- Reset during RUN: immediate return to the reset values; the pending tc is discarded.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - At the terminal event, out <= reload register, tc <= 1, state stays RUN.
  - done never asserts.
  - Period is exactly the reload value in enabled cycles; with reload value 1, tc is high every enabled cycle.
- Undefined:
  - Terminal event goes to DONE as above.
  - The reload register exists but is used only to hold the loaded value.

Test Plan:
- reset=0 for 2 edges with load=1, data=8'hAA -> out=0, tc=0, busy=0, done=0.
- load data=5, then en=1 for 6 edges -> out 5,4,3,2,1,0; tc=1 only in the cycle out first reads 0; then done=1, busy=0, out holds 0.
- load 4, en=1 for 2 edges, en=0 for 3 edges, en=1 -> out 4,3,2,2,2,2,1,0; tc exactly once.
- load 3, run to out=1; on the terminal edge load=1, data=7 -> out=7, tc=0, busy=1.
- load data=0 -> out=0, state IDLE, busy=0, done=0, no tc for 10 cycles with en=1.
- With DOWN_COUNTER_AUTO_RELOAD_EN: load 3, en=1 for 9 edges -> out 3,2,1,3,2,1,3,2,1,3 (the loaded 3 plus one value per edge); tc pulses at each 1->3 transition (3 pulses); done stays 0.
